// File: rtl/minmax_stream_reducer.sv
// -----------------------------------------------------------------------------
// minmax_stream_reducer
//
// Purpose:
//   Multi-cycle stream reduction unit. After a start pulse it accepts `count`
//   operands over a valid/ready handshake and reports the minimum and maximum
//   sample together with the 0-based index of each. Comparison is signed or
//   unsigned as selected by sign_ctrl, which is latched at start. Results are
//   held in DONE until the consumer accepts them. They remain on the outputs
//   after that, until the first sample of the next reduction overwrites them.
//
// Optional feature (compile-time macro MINMAX_ABORT_EN):
//   Adds an `abort` input and an `aborted` status output. When abort is high
//   in ACCUM, the unit terminates early. A transfer in the same cycle is
//   accepted first.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a reduction (sampled only in IDLE)
//   count      in   [CNT_W]  number of samples, latched on start
//   sign_ctrl  in   0 = unsigned compare, 1 = signed compare, latched on start
//   in_valid   in   in_data valid
//   in_ready   out  unit accepts in_data this cycle (high in ACCUM)
//   in_data    in   [DATA_W] sample
//   out_valid  out  results valid and held (high in DONE)
//   out_ready  in   consumer accepts results
//   min_val    out  [DATA_W] minimum sample
//   max_val    out  [DATA_W] maximum sample
//   min_idx    out  [CNT_W]  index of the minimum
//   max_idx    out  [CNT_W]  index of the maximum
//   busy       out  high in ACCUM or DONE
//   abort      in   (MINMAX_ABORT_EN only) terminate the reduction early
//   aborted    out  (MINMAX_ABORT_EN only) last reduction was aborted
// -----------------------------------------------------------------------------
module minmax_stream_reducer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              sign_ctrl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [CNT_W-1:0]  min_idx,
    output logic [CNT_W-1:0]  max_idx,
    output logic              busy
`ifdef MINMAX_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]    min_idx_q, min_idx_d;
    logic [CNT_W-1:0]    max_idx_q, max_idx_d;
`ifdef MINMAX_ABORT_EN
    logic                aborted_q, aborted_d;
`endif

    logic                xfer;
    logic                last_xfer;
    logic                start_ok;
    logic [CNT_W-1:0]    cnt_inc;

    // a < b under the selected interpretation (two's complement or magnitude)
    function automatic logic less_than(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input logic              is_signed);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        return is_signed ? (sa < sb) : (a < b);
    endfunction

    // in_ready is decoded from state, so a transfer is simply in_valid in ACCUM
    assign xfer      = (state_q == S_ACCUM) && in_valid;
    assign cnt_inc   = cnt_q + 1'b1;
    // The counter never exceeds len-1 before this fires, so cnt_inc cannot wrap
    assign last_xfer = xfer && (cnt_inc == len_q);
    assign start_ok  = (state_q == S_IDLE) && start && (count != '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_xfer) begin
                    state_d = S_DONE;
                end
`ifdef MINMAX_ABORT_EN
                if (abort) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- reduction datapath ----------------
    always_comb begin
        cnt_d     = cnt_q;
        len_d     = len_q;
        sign_d    = sign_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`ifdef MINMAX_ABORT_EN
        aborted_d = aborted_q;
`endif

        if (start_ok) begin
            len_d  = count;
            sign_d = sign_ctrl;
            cnt_d  = '0;
`ifdef MINMAX_ABORT_EN
            aborted_d = 1'b0;
`endif
        end

        if (xfer) begin
            cnt_d = cnt_inc;
            if (cnt_q == '0) begin
                // The first sample seeds both extremes
                min_d     = in_data;
                max_d     = in_data;
                min_idx_d = '0;
                max_idx_d = '0;
            end else begin
                // Strict compares keep the earliest index on ties
                if (less_than(in_data, min_q, sign_q)) begin
                    min_d     = in_data;
                    min_idx_d = cnt_q;
                end
                if (less_than(max_q, in_data, sign_q)) begin
                    max_d     = in_data;
                    max_idx_d = cnt_q;
                end
            end
        end

`ifdef MINMAX_ABORT_EN
        if ((state_q == S_ACCUM) && abort) begin
            aborted_d = 1'b1;
            // With nothing accepted, the held results are from an earlier
            // run, so clear them rather than report stale values.
            if (!xfer && (cnt_q == '0)) begin
                min_d     = '0;
                max_d     = '0;
                min_idx_d = '0;
                max_idx_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_q     <= '0;
            sign_q    <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
`ifdef MINMAX_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sign_q    <= sign_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`ifdef MINMAX_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
    assign min_idx = min_idx_q;
    assign max_idx = max_idx_q;
`ifdef MINMAX_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_minmax_stream_reducer.sv
// -----------------------------------------------------------------------------
// tb_minmax_stream_reducer
//
// Directed bench for minmax_stream_reducer. Inputs change 1 time unit after
// each rising edge, and outputs are sampled at the same point. Expected values
// are hand-computed constants. When MINMAX_ABORT_EN is defined, the abort
// scenarios are also exercised.
// -----------------------------------------------------------------------------
module tb_minmax_stream_reducer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  count;
    logic              sign_ctrl;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] max_val;
    logic [CNT_W-1:0]  min_idx;
    logic [CNT_W-1:0]  max_idx;
    logic              busy;
`ifdef MINMAX_ABORT_EN
    logic              abort;
    logic              aborted;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    minmax_stream_reducer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .sign_ctrl (sign_ctrl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min_val   (min_val),
        .max_val   (max_val),
        .min_idx   (min_idx),
        .max_idx   (max_idx),
        .busy      (busy)
`ifdef MINMAX_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample after `gap` idle cycles; in ACCUM it transfers on the edge
    task automatic feed(input logic [31:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            tick();
            check("stall_busy", busy, 1);
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [CNT_W-1:0] n, input logic sgn);
        start     = 1'b1;
        count     = n;
        sign_ctrl = sgn;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_results(input string tag,
                                 input logic [31:0] mn, input logic [31:0] mni,
                                 input logic [31:0] mx, input logic [31:0] mxi);
        check({tag, "_min"},     min_val, mn);
        check({tag, "_min_idx"}, min_idx, mni);
        check({tag, "_max"},     max_val, mx);
        check({tag, "_max_idx"}, max_idx, mxi);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        count     = '0;
        sign_ctrl = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MINMAX_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check_results("rst", 0, 0, 0, 0);

        // start with count==0 is ignored
        begin_run(16'd0, 1'b0);
        check("cnt0_busy", busy, 0);
        check("cnt0_in_ready", in_ready, 0);
        tick();
        check("cnt0_busy_later", busy, 0);

        // Unsigned, count=4, back-to-back samples
        begin_run(16'd4, 1'b0);
        check("u_in_ready", in_ready, 1);
        check("u_busy", busy, 1);
        feed(32'd5, 0);
        feed(32'hFFFF_FFFF, 0);
        feed(32'd3, 0);
        check("u_no_early_valid", out_valid, 0);
        feed(32'd9, 0);
        check("u_out_valid", out_valid, 1);
        check("u_in_ready_drop", in_ready, 0);
        check_results("u", 32'd3, 2, 32'hFFFF_FFFF, 1);
        finish_run();
        check("u_out_valid_drop", out_valid, 0);
        check("u_busy_drop", busy, 0);
        check("u_held_min", min_val, 32'd3);

        // Signed, same samples
        begin_run(16'd4, 1'b1);
        feed(32'd5, 0);
        feed(32'hFFFF_FFFF, 0);
        feed(32'd3, 0);
        feed(32'd9, 0);
        check("s_out_valid", out_valid, 1);
        check_results("s", 32'hFFFF_FFFF, 1, 32'd9, 3);
        finish_run();

        // Ties, unsigned, in_valid toggling
        begin_run(16'd5, 1'b0);
        feed(32'd7, 0);
        feed(32'd2, 1);
        feed(32'd7, 1);
        feed(32'd2, 1);
        feed(32'd1, 1);
        check("t_out_valid", out_valid, 1);
        check("t_busy", busy, 1);
        // Offer a smaller value: it must not be accepted
        in_valid = 1'b1;
        in_data  = 32'd0;
        tick();
        in_valid = 1'b0;
        check("t_in_ready", in_ready, 0);
        check_results("t", 32'd1, 4, 32'd7, 0);
        finish_run();

        // count=1 signed, results held while out_ready low, start ignored
        begin_run(16'd1, 1'b1);
        feed(32'h8000_0000, 0);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            count = 16'd3;
            tick();
            check("h_out_valid", out_valid, 1);
            check("h_min", min_val, 32'h8000_0000);
            check("h_max", max_val, 32'h8000_0000);
        end
        start = 1'b0;
        check_results("h", 32'h8000_0000, 0, 32'h8000_0000, 0);

        // start during the DONE->IDLE cycle is ignored, taken in next IDLE cycle
        start     = 1'b1;
        count     = 16'd4;
        sign_ctrl = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rs_idle_busy", busy, 0);
        tick();
        start = 1'b0;
        check("rs_accum_busy", busy, 1);
        check("rs_accum_in_ready", in_ready, 1);

        // Reset after 2 of 4 samples
        feed(32'd10, 0);
        feed(32'd20, 0);
        check("pre_rst_min", min_val, 32'd10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy", busy, 0);
        check("mr_in_ready", in_ready, 0);
        check("mr_out_valid", out_valid, 0);
        check_results("mr", 0, 0, 0, 0);
        tick();
        check("mr_stay_idle", busy, 0);

`ifdef MINMAX_ABORT_EN
        // Abort after 3 of 8 samples
        begin_run(16'd8, 1'b0);
        feed(32'd4, 0);
        feed(32'd1, 0);
        feed(32'd6, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_out_valid", out_valid, 1);
        check("ab_aborted", aborted, 1);
        check_results("ab", 32'd1, 1, 32'd6, 2);
        finish_run();
        check("ab_aborted_held", aborted, 1);
        begin_run(16'd3, 1'b0);
        check("ab_aborted_clr", aborted, 0);

        // Abort with zero samples accepted
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab0_out_valid", out_valid, 1);
        check("ab0_aborted", aborted, 1);
        check_results("ab0", 0, 0, 0, 0);
        finish_run();
        check("ab0_idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
